// File: rtl/rw_manager_ac_sequencer.sv
// rtl/rw_manager_ac_sequencer.sv - AC ROM command sequencer with repeat passes and ready/valid output
// Optional build macro: AC_SEQ_NOP_SKIP_EN (zero-valued ROM words are consumed without being presented)
module rw_manager_ac_sequencer #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int LOOP_WIDTH  = 8,
    parameter int ROM_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic [LOOP_WIDTH-1:0] loop_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_rdaddress,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] cmd_word
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_FINISH
    } state_t;

    // The address is registered out of FETCH, so the ROM sees it one cycle later;
    // WAIT therefore spans ROM_LATENCY+1 cycles before rom_q is safe to capture.
    localparam logic [2:0] WAIT_LAST = 3'(ROM_LATENCY);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] nw_q, nw_d;
    logic [LOOP_WIDTH-1:0] pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [2:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] rdaddr_q, rdaddr_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    logic                  advance;
    logic [ADDR_WIDTH:0]   idx_inc;
    logic                  more_words;

    assign idx_inc    = {1'b0, idx_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign more_words = idx_inc < {1'b0, nw_q};

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        nw_d     = nw_q;
        pass_d   = pass_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        rdaddr_d = rdaddr_q;
        word_d   = word_q;
        advance  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_d = start_addr;
                    nw_d    = num_words;
                    pass_d  = loop_count;
                    addr_d  = start_addr;
                    idx_d   = '0;
                    state_d = (num_words == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                rdaddr_d = addr_q;
                wait_d   = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    word_d = rom_q;
`ifdef AC_SEQ_NOP_SKIP_EN
                    if (rom_q == '0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_PRESENT;
                    end
`else
                    state_d = S_PRESENT;
`endif
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_PRESENT: begin
                if (cmd_ready) begin
                    advance = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Step to the next word, restart the pass, or finish.
        if (advance) begin
            if (more_words) begin
                idx_d   = idx_inc[ADDR_WIDTH-1:0];
                addr_d  = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                state_d = S_FETCH;
            end else if (pass_q != '0) begin
                idx_d   = '0;
                addr_d  = start_q;
                pass_d  = pass_q - {{(LOOP_WIDTH-1){1'b0}}, 1'b1};
                state_d = S_FETCH;
            end else begin
                state_d = S_FINISH;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            start_q  <= '0;
            nw_q     <= '0;
            pass_q   <= '0;
            addr_q   <= '0;
            idx_q    <= '0;
            wait_q   <= '0;
            rdaddr_q <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            nw_q     <= nw_d;
            pass_q   <= pass_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            rdaddr_q <= rdaddr_d;
            word_q   <= word_d;
        end
    end

    assign busy          = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done          = (state_q == S_FINISH);
    assign cmd_valid     = (state_q == S_PRESENT);
    assign cmd_word      = word_q;
    assign rom_rdaddress = rdaddr_q;

endmodule

// File: tb/tb_rw_manager_ac_sequencer.sv
// tb/tb_rw_manager_ac_sequencer.sv - directed self-checking bench for rw_manager_ac_sequencer
module tb_rw_manager_ac_sequencer;

    localparam int L = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  start_addr = '0;
    logic [5:0]  num_words = '0;
    logic [7:0]  loop_count = '0;
    logic        busy;
    logic        done;
    logic [5:0]  rom_rdaddress;
    logic [31:0] rom_q;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [31:0] cmd_word;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rom [64];
    logic [31:0] pipe [L];
    logic [31:0] hs_q [$];
    int          done_cnt = 0;

    always #5 clock = ~clock;

    rw_manager_ac_sequencer #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .LOOP_WIDTH (8),
        .ROM_LATENCY(L)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .num_words    (num_words),
        .loop_count   (loop_count),
        .busy         (busy),
        .done         (done),
        .rom_rdaddress(rom_rdaddress),
        .rom_q        (rom_q),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_word     (cmd_word)
    );

    // ROM model: data for an address appears L cycles after the address does
    always @(posedge clock) begin
        pipe[0] <= rom[rom_rdaddress];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_q = pipe[L-1];

    always @(posedge clock) begin
        if (!reset && cmd_valid && cmd_ready) hs_q.push_back(cmd_word);
        if (!reset && done) done_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_seq(input logic [5:0] a, input logic [5:0] n, input logic [7:0] l);
        start_addr = a;
        num_words  = n;
        loop_count = l;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        step();
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_valid_seen"}, {31'd0, cmd_valid}, 32'd1);
    endtask

    initial begin
        int hb;
        int db;
        int bad;

        for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | i;
        rom[6'h02] = 32'h0C01_0231;
        rom[6'h03] = 32'h0C01_0330;
        rom[6'h04] = 32'h0C01_2000;
        rom[6'h14] = 32'h0F33_0000;
        rom[6'h15] = 32'h0F33_6000;
        rom[6'h24] = 32'h0000_0000;
        rom[6'h25] = 32'h0000_0000;
        rom[6'h3F] = 32'hAAAA_003F;
        rom[6'h00] = 32'h5555_0000;

        // Reset values
        reset = 1'b1;
        step(); step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_word", cmd_word, 32'd0);
        chk("rst_rdaddr", {26'd0, rom_rdaddress}, 32'd0);
        reset = 1'b0;
        step();

        // Basic three-word pass and first-word latency
        hb = hs_q.size(); db = done_cnt;
        cmd_ready = 1'b1;
        start_seq(6'h02, 6'd3, 8'd0);
        chk("A_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < L + 1; i++) step();
        chk("A_valid_early", {31'd0, cmd_valid}, 32'd0);
        step();
        chk("A_valid_latency", {31'd0, cmd_valid}, 32'd1);
        chk("A_first_word", cmd_word, 32'h0C01_0231);
        wait_done("A", 100);
        chk("A_count", hs_q.size() - hb, 32'd3);
        chk("A_w0", hs_q[hb], 32'h0C01_0231);
        chk("A_w1", hs_q[hb+1], 32'h0C01_0330);
        chk("A_w2", hs_q[hb+2], 32'h0C01_2000);
        chk("A_done_cnt", done_cnt - db, 32'd1);

        // Three passes; a start while busy must not disturb the latched parameters
        hb = hs_q.size(); db = done_cnt;
        start_seq(6'h14, 6'd2, 8'd2);
        step(); step(); step();
        start_seq(6'h02, 6'd1, 8'd0);
        wait_done("B", 200);
        chk("B_count", hs_q.size() - hb, 32'd6);
        for (int i = 0; i < 6; i++)
            chk("B_word", hs_q[hb+i], (i % 2 == 1) ? 32'h0F33_6000 : 32'h0F33_0000);
        chk("B_done_cnt", done_cnt - db, 32'd1);

        // Back-pressure on the second word
        hb = hs_q.size();
        cmd_ready = 1'b0;
        start_seq(6'h02, 6'd3, 8'd0);
        wait_valid("C_w0", 20);
        chk("C_w0_word", cmd_word, 32'h0C01_0231);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        wait_valid("C_w1", 20);
        chk("C_w1_word", cmd_word, 32'h0C01_0330);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd_valid !== 1'b1 || cmd_word !== 32'h0C01_0330 || rom_rdaddress !== 6'h03) bad++;
        end
        chk("C_stall_stable", bad, 32'd0);
        cmd_ready = 1'b1;
        wait_done("C", 100);
        chk("C_count", hs_q.size() - hb, 32'd3);
        chk("C_w2", hs_q[hb+2], 32'h0C01_2000);

        // Address wrap at the top of the ROM
        hb = hs_q.size();
        start_seq(6'h3F, 6'd2, 8'd0);
        step();
        chk("D_addr_first", {26'd0, rom_rdaddress}, 32'h3F);
        wait_done("D", 100);
        chk("D_addr_hold", {26'd0, rom_rdaddress}, 32'h00);
        chk("D_w0", hs_q[hb], 32'hAAAA_003F);
        chk("D_w1", hs_q[hb+1], 32'h5555_0000);

        // Zero-length sequence
        hb = hs_q.size(); db = done_cnt;
        start_seq(6'h05, 6'd0, 8'd3);
        chk("E_done", {31'd0, done}, 32'd1);
        chk("E_valid", {31'd0, cmd_valid}, 32'd0);
        wait_done("E", 5);
        chk("E_count", hs_q.size() - hb, 32'd0);
        chk("E_done_cnt", done_cnt - db, 32'd1);

        // Reset in the middle of a presented word
        cmd_ready = 1'b0;
        start_seq(6'h14, 6'd2, 8'd2);
        wait_valid("F_pre", 20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("F_busy", {31'd0, busy}, 32'd0);
        chk("F_valid", {31'd0, cmd_valid}, 32'd0);
        chk("F_done", {31'd0, done}, 32'd0);
        chk("F_word", cmd_word, 32'd0);
        step(); step(); step();
        chk("F_no_represent", {31'd0, cmd_valid}, 32'd0);
        hb = hs_q.size(); db = done_cnt;
        cmd_ready = 1'b1;
        start_seq(6'h02, 6'd1, 8'd0);
        wait_done("F", 50);
        chk("F_count", hs_q.size() - hb, 32'd1);
        chk("F_w0", hs_q[hb], 32'h0C01_0231);
        chk("F_done_cnt", done_cnt - db, 32'd1);

        // Zero-valued words
        hb = hs_q.size(); db = done_cnt;
        start_seq(6'h24, 6'd2, 8'd0);
        wait_done("G", 100);
`ifdef AC_SEQ_NOP_SKIP_EN
        chk("G_count", hs_q.size() - hb, 32'd0);
`else
        chk("G_count", hs_q.size() - hb, 32'd2);
        chk("G_w0", hs_q[hb], 32'd0);
        chk("G_w1", hs_q[hb+1], 32'd0);
`endif
        chk("G_done_cnt", done_cnt - db, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
